y86_imem_loader: RTL and testbench

Byte-stream program loader for the pipelined Y86 core: it is the writer side of the instruction memory that the fetch stage reads. It accepts a length-prefixed, checksummed frame over a valid/ready byte stream and writes the payload into instruction memory through a one-byte write port. It holds the core off via `cpu_hold` until a good image is in place. On a malformed frame it stops in an error state until the next `start`.

---
 rtl/y86_imem_loader_if.sv | 28 ++
 rtl/y86_imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_y86_imem_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_imem_loader_if.sv
`default_nettype none
//==============================================================================
// Module   : y86_imem_loader_if
// Brief    : Byte-stream input and instruction-memory write port of the loader.
// Revision : 1.0
//==============================================================================
interface y86_imem_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   // master: byte source / memory owner; slave: the loader itself
   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/y86_imem_loader.sv
`default_nettype none
//==============================================================================
// Module   : y86_imem_loader
// Brief    : Length-prefixed byte-stream loader for the Y86 instruction memory.
//            Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
// Revision : 1.0
//==============================================================================
module y86_imem_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   y86_imem_loader_if.slave bus,
   output logic             cpu_hold,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [15:0]      byte_count
);

   localparam logic [16:0]       c_DEPTH = 17'(1) << ADDR_W;
   localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);

`ifdef IMEM_LOADER_CSUM_EN
   typedef enum logic [2:0] {
      S_LEN0 = 3'd0,
      S_LEN1 = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;
   localparam state_t c_AFTER_DATA = S_CSUM;
`else
   typedef enum logic [2:0] {
      S_LEN0 = 3'd0,
      S_LEN1 = 3'd1,
      S_DATA = 3'd2,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;
   localparam state_t c_AFTER_DATA = S_DONE;
`endif

   state_t            r_state;
   state_t            w_nextState;
   logic [1:0]        r_errCode;
   logic [1:0]        w_nextErrCode;
   logic              w_accept;
   logic              w_rearm;
   logic [15:0]       w_len;
   logic              w_lenTooBig;
   logic [7:0]        r_lenLo;
   logic [15:0]       r_remain;
   logic [ADDR_W-1:0] r_wrAddr;
   logic              r_memWe;
   logic [ADDR_W-1:0] r_memAddr;
   logic [7:0]        r_memWdata;
   logic [15:0]       r_byteCount;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]        r_xor;
`endif

   assign bus.in_ready = !rst && (r_state != S_DONE) && (r_state != S_ERR);
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_rearm      = start && ((r_state == S_DONE) || (r_state == S_ERR));
   // Length is only meaningful while LEN_HI is on the bus
   assign w_len        = {bus.in_data, r_lenLo};
   assign w_lenTooBig  = {1'b0, w_len} > c_DEPTH;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_LEN0;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState   = r_state;
      w_nextErrCode = r_errCode;
      case (r_state)
         S_LEN0: begin
            if (w_accept) begin
               w_nextState = S_LEN1;
            end
         end
         S_LEN1: begin
            if (w_accept) begin
               if (w_lenTooBig) begin
                  w_nextState   = S_ERR;
                  w_nextErrCode = 2'd1;
               end else if (w_len == 16'd0) begin
                  w_nextState = c_AFTER_DATA;
               end else begin
                  w_nextState = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_accept && (r_remain == 16'd0)) begin
               w_nextState = c_AFTER_DATA;
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         S_CSUM: begin
            if (w_accept) begin
               if (bus.in_data == r_xor) begin
                  w_nextState = S_DONE;
               end else begin
                  w_nextState   = S_ERR;
                  w_nextErrCode = 2'd2;
               end
            end
         end
`endif
         S_DONE, S_ERR: begin
            if (start) begin
               w_nextState   = S_LEN0;
               w_nextErrCode = 2'd0;
            end
         end
         default: begin
            w_nextState = S_LEN0;
         end
      endcase
   end

   // Datapath: write port, counters and running checksum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_errCode   <= 2'd0;
         r_lenLo     <= 8'd0;
         r_remain    <= 16'd0;
         r_wrAddr    <= c_BASE;
         r_memWe     <= 1'b0;
         r_memAddr   <= '0;
         r_memWdata  <= 8'd0;
         r_byteCount <= 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
         r_xor       <= 8'd0;
`endif
      end else begin
         r_errCode <= w_nextErrCode;
         r_memWe   <= 1'b0;
         if (w_rearm) begin
            r_byteCount <= 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
            r_xor       <= 8'd0;
`endif
         end
         if (w_accept && (r_state == S_LEN0)) begin
            r_lenLo <= bus.in_data;
         end
         // remain holds L-1 so the last byte is seen at zero
         if (w_accept && (r_state == S_LEN1)) begin
            r_remain <= w_len - 16'd1;
            r_wrAddr <= c_BASE;
         end
         if (w_accept && (r_state == S_DATA)) begin
            r_memWe     <= 1'b1;
            r_memAddr   <= r_wrAddr;
            r_memWdata  <= bus.in_data;
            r_wrAddr    <= r_wrAddr + ADDR_W'(1);
            r_remain    <= r_remain - 16'd1;
            r_byteCount <= r_byteCount + 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
            r_xor       <= r_xor ^ bus.in_data;
`endif
         end
      end
   end

   assign bus.mem_we    = r_memWe;
   assign bus.mem_addr  = r_memAddr;
   assign bus.mem_wdata = r_memWdata;
   assign cpu_hold      = (r_state != S_DONE);
   assign done          = (r_state == S_DONE);
   assign err           = (r_state == S_ERR);
   assign err_code      = r_errCode;
   assign byte_count    = r_byteCount;

endmodule
`default_nettype wire

// File: tb/tb_y86_imem_loader.sv
`default_nettype none
//==============================================================================
// Module   : tb_y86_imem_loader
// Brief    : Bench for y86_imem_loader: a 10-bit/base-0 loader and a 4-bit/base-14 one.
// Revision : 1.0
//==============================================================================
module tb_y86_imem_loader;

   localparam int A_AW   = 10;
   localparam int A_BASE = 0;
   localparam int B_AW   = 4;
   localparam int B_BASE = 14;
`ifdef IMEM_LOADER_CSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        startS[2];
   logic        validS[2];
   logic [7:0]  dataS[2];
   logic        readyS[2];
   logic        weS[2];
   logic [15:0] addrS[2];
   logic [7:0]  wdataS[2];
   logic        holdS[2];
   logic        doneS[2];
   logic        errS[2];
   logic [1:0]  codeS[2];
   logic [15:0] cntS[2];

   int checks = 0;
   int errors = 0;

   logic [7:0]  fr[$];
   logic [23:0] logA[0:4095];
   logic [23:0] logB[0:4095];
   int          nA = 0;
   int          nB = 0;

   y86_imem_loader_if #(.ADDR_W(A_AW)) busA();
   y86_imem_loader_if #(.ADDR_W(B_AW)) busB();

   assign busA.in_valid = validS[0];
   assign busA.in_data  = dataS[0];
   assign busB.in_valid = validS[1];
   assign busB.in_data  = dataS[1];
   assign readyS[0] = busA.in_ready;
   assign weS[0]    = busA.mem_we;
   assign addrS[0]  = 16'(busA.mem_addr);
   assign wdataS[0] = busA.mem_wdata;
   assign readyS[1] = busB.in_ready;
   assign weS[1]    = busB.mem_we;
   assign addrS[1]  = 16'(busB.mem_addr);
   assign wdataS[1] = busB.mem_wdata;

   y86_imem_loader #(.ADDR_W(A_AW), .BASE_ADDR(A_BASE)) dutA (
      .clk(clk), .rst(rst), .start(startS[0]), .bus(busA.slave),
      .cpu_hold(holdS[0]), .done(doneS[0]), .err(errS[0]),
      .err_code(codeS[0]), .byte_count(cntS[0])
   );

   y86_imem_loader #(.ADDR_W(B_AW), .BASE_ADDR(B_BASE)) dutB (
      .clk(clk), .rst(rst), .start(startS[1]), .bus(busB.slave),
      .cpu_hold(holdS[1]), .done(doneS[1]), .err(errS[1]),
      .err_code(codeS[1]), .byte_count(cntS[1])
   );

   always #5 clk = ~clk;

   // Write monitors: every strobed (addr, data) pair outside reset
   always @(negedge clk) begin
      if (!rst && weS[0] && nA < 4096) begin
         logA[nA] = {addrS[0], wdataS[0]};
         nA = nA + 1;
      end
   end
   always @(negedge clk) begin
      if (!rst && weS[1] && nB < 4096) begin
         logB[nB] = {addrS[1], wdataS[1]};
         nB = nB + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int logN(input int d);
      return (d == 0) ? nA : nB;
   endfunction

   function automatic logic [23:0] logAt(input int d, input int idx);
      return (d == 0) ? logA[idx] : logB[idx];
   endfunction

   task automatic checkReset(input int d, input string tag);
      chk({tag, ":in_ready"},   32'(readyS[d]), 32'd0);
      chk({tag, ":cpu_hold"},   32'(holdS[d]),  32'd1);
      chk({tag, ":done"},       32'(doneS[d]),  32'd0);
      chk({tag, ":err"},        32'(errS[d]),   32'd0);
      chk({tag, ":err_code"},   32'(codeS[d]),  32'd0);
      chk({tag, ":mem_we"},     32'(weS[d]),    32'd0);
      chk({tag, ":mem_addr"},   32'(addrS[d]),  32'd0);
      chk({tag, ":mem_wdata"},  32'(wdataS[d]), 32'd0);
      chk({tag, ":byte_count"}, 32'(cntS[d]),   32'd0);
   endtask

   // Presents fr[0..n-1] with random idle gaps; stops early once in_ready drops.
   task automatic driveBytes(input int d, input int n, input int gapPct, output int cons);
      int g;
      cons = 0;
      @(negedge clk);
      for (int k = 0; k < n; k++) begin
         g = 0;
         while (g < 4 && int'($urandom_range(99)) < gapPct) begin
            validS[d] = 1'b0;
            @(negedge clk);
            g++;
         end
         validS[d] = 1'b1;
         dataS[d]  = fr[k];
         #1;
         if (!readyS[d]) break;
         @(negedge clk);
         cons++;
      end
      validS[d] = 1'b0;
   endtask

   task automatic pulseStart(input int d, input string tag);
      @(negedge clk);
      startS[d] = 1'b1;
      @(negedge clk);
      startS[d] = 1'b0;
      #1;
      chk({tag, ":done"},       32'(doneS[d]), 32'd0);
      chk({tag, ":err"},        32'(errS[d]),  32'd0);
      chk({tag, ":err_code"},   32'(codeS[d]), 32'd0);
      chk({tag, ":byte_count"}, 32'(cntS[d]),  32'd0);
      chk({tag, ":cpu_hold"},   32'(holdS[d]), 32'd1);
      chk({tag, ":in_ready"},   32'(readyS[d]), 32'd1);
   endtask

   // Frame-level reference: outcome computed from the frame bytes alone.
   task automatic runFrame(input int d, input int gapPct, input string tag);
      int depth, base, len, expCons, expCnt, nW, cons, b0, nAfter;
      logic expDone, expErr;
      logic [1:0] expCode;
      logic [7:0] x;
      depth = 1 << ((d == 0) ? A_AW : B_AW);
      base  = (d == 0) ? A_BASE : B_BASE;
      len   = int'(fr[1]) * 256 + int'(fr[0]);
      x     = 8'd0;
      if (len > depth) begin
         expCons = 2; nW = 0; expCnt = 0;
         expDone = 1'b0; expErr = 1'b1; expCode = 2'd1;
      end else begin
         for (int i = 0; i < len; i++) x = x ^ fr[2 + i];
         nW = len; expCnt = len;
         expCons = CSUM_EN ? len + 3 : len + 2;
         if (!CSUM_EN || fr[len + 2] == x) begin
            expDone = 1'b1; expErr = 1'b0; expCode = 2'd0;
         end else begin
            expDone = 1'b0; expErr = 1'b1; expCode = 2'd2;
         end
      end
      b0 = logN(d);
      driveBytes(d, fr.size(), gapPct, cons);
      #1;
      chk({tag, ":consumed"},   32'(cons),      32'(expCons));
      chk({tag, ":done"},       32'(doneS[d]),  32'(expDone));
      chk({tag, ":err"},        32'(errS[d]),   32'(expErr));
      chk({tag, ":err_code"},   32'(codeS[d]),  32'(expCode));
      chk({tag, ":cpu_hold"},   32'(holdS[d]),  32'(!expDone));
      chk({tag, ":byte_count"}, 32'(cntS[d]),   32'(expCnt));
      chk({tag, ":in_ready"},   32'(readyS[d]), 32'd0);
      chk({tag, ":writes"},     32'(logN(d) - b0), 32'(nW));
      for (int i = 0; i < nW; i++) begin
         chk({tag, ":write"}, 32'(logAt(d, b0 + i)), 32'({16'((base + i) % depth), fr[2 + i]}));
      end
      nAfter = logN(d);
      repeat (3) @(negedge clk);
      #1;
      chk({tag, ":no_late_write"}, 32'(logN(d)), 32'(nAfter));
      chk({tag, ":done_hold"},     32'(doneS[d]), 32'(expDone));
   endtask

   task automatic buildFrame(input int len, input int depth, input bit corrupt);
      logic [15:0] l16;
      logic [7:0]  x, b;
      l16 = 16'(len);
      x   = 8'd0;
      fr  = {};
      fr.push_back(l16[7:0]);
      fr.push_back(l16[15:8]);
      if (len > depth) begin
         fr.push_back(8'hEE);
         fr.push_back(8'hEE);
      end else begin
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(255));
            fr.push_back(b);
            x = x ^ b;
         end
         if (CSUM_EN) fr.push_back(corrupt ? (x ^ 8'h5A) : x);
      end
   endtask

   initial begin
      int cons, n0, nPre, len;
      for (int d = 0; d < 2; d++) begin
         startS[d] = 1'b0;
         validS[d] = 1'b0;
         dataS[d]  = 8'h00;
      end
      rst = 1'b1;
      #3;
      checkReset(0, "reset_A");
      checkReset(1, "reset_B");
      @(negedge clk);
      rst = 1'b0;

      // Basic frame, one byte per cycle; checksum is the payload XOR (0xCA)
      fr = {8'h03, 8'h00, 8'h30, 8'hF0, 8'h0A};
      if (CSUM_EN) fr.push_back(8'hCA);
      runFrame(0, 0, "basic");

`ifdef IMEM_LOADER_CSUM_EN
      pulseStart(0, "start_csum");
      fr = {8'h03, 8'h00, 8'h30, 8'hF0, 8'h0A, 8'h00};
      runFrame(0, 0, "bad_csum");
      pulseStart(0, "rearm_err");
      fr = {8'h03, 8'h00, 8'h30, 8'hF0, 8'h0A, 8'hCA};
      runFrame(0, 0, "resend");
`endif

      // Oversize length on the 16-byte memory; trailing bytes must be refused
      fr = {8'h11, 8'h00, 8'hAA, 8'hBB};
      runFrame(1, 0, "len_17");
      pulseStart(1, "rearm_len");
      buildFrame(16, 16, 1'b0);
      runFrame(1, 20, "len_16");
      pulseStart(1, "rearm_wrap");
      fr = {8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      if (CSUM_EN) fr.push_back(8'h04);
      runFrame(1, 0, "wrap");

      for (int r = 0; r < 8; r++) begin
         pulseStart(0, "rnd_start");
         len = ($urandom_range(7) == 0) ? 1025 + int'($urandom_range(500)) : int'($urandom_range(40));
         buildFrame(len, 1024, $urandom_range(3) == 0);
         runFrame(0, 30, "rnd");
      end

      // Reset in the middle of a payload
      pulseStart(0, "abort_start");
      buildFrame(6, 1024, 1'b0);
      nPre = nA;
      driveBytes(0, 4, 30, cons);
      chk("abort:consumed", 32'(cons), 32'd4);
      #2;
      rst = 1'b1;
      #1;
      checkReset(0, "abort_A");
      checkReset(1, "abort_B");
      n0 = nA;
      chk("abort:pre_writes", 32'(n0 - nPre), 32'd2);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("abort:no_write_after", 32'(nA), 32'(n0));
      chk("abort:byte_count", 32'(cntS[0]), 32'd0);
      buildFrame(9, 1024, 1'b0);
      runFrame(0, 30, "after_abort");

      // Empty image
      pulseStart(0, "empty_start");
      fr = {8'h00, 8'h00};
      if (CSUM_EN) fr.push_back(8'h00);
      runFrame(0, 0, "empty");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
